// File: rtl/alu_div_pkg.sv
// Shared definitions for the non-restoring divider.
//   div_state_t   : controller states
//   DIV0_Q_FILL   : bit value replicated across the quotient on divide-by-zero
//   DIV0_FLAG     : value of div_by_zero reported for a zero divisor
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } div_state_t;

    localparam logic DIV0_Q_FILL = 1'b1;
    localparam logic DIV0_FLAG   = 1'b1;

endpackage

// File: rtl/alu_div_step.sv
// One combinational non-restoring division iteration.
//   a      : partial remainder, WIDTH+1 bits, two's complement
//   q      : partial quotient / remaining dividend bits
//   m      : divisor magnitude, zero-extended to WIDTH+1 bits
//   a_next : partial remainder after shift and add/subtract
//   q_next : quotient after shift with the new bit inserted
module alu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_shift;

    // The add/subtract decision uses the sign of A before the shift; any
    // wrap of the shifted value is undone modulo 2^(WIDTH+1) by the +/-M.
    always_comb begin
        a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
        if (!a[WIDTH]) begin
            a_next = a_shift - m;
        end else begin
            a_next = a_shift + m;
        end
        q_next = {q[WIDTH-2:0], ~a_next[WIDTH]};
    end

endmodule

// File: rtl/alu_div_nr.sv
// Multi-cycle non-restoring integer divider, signed or unsigned.
//   clk, resetn        : clock, synchronous active-low reset
//   start              : request, accepted only in IDLE
//   is_signed          : two's-complement operands when 1 (sampled with start)
//   dividend, divisor  : operands (sampled with start)
//   busy               : operation in progress (accept cycle+1 through done)
//   done               : one-cycle pulse, results valid
//   quotient/remainder : truncating results, held until the next result
//   div_by_zero        : divisor was zero, held with the results
module alu_div_nr
    import alu_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t state, state_next;

    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH:0]   m_reg;
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH:0]   a_fix;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    always_comb begin
        accept       = (state == IDLE) && start;
        divisor_zero = (divisor == '0);
        dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        a_fix        = a_reg[WIDTH] ? (a_reg + m_reg) : a_reg;
        quot_final   = q_neg ? -q_reg : q_reg;
        rem_final    = r_neg ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = divisor_zero ? FIN : ITER;
            ITER: if (count == CNT_W'(1)) state_next = FIX;
            FIX:  state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        busy = (state != IDLE);
        done = (state == FIN);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            a_reg <= '0;
            q_reg <= dividend_mag;
            m_reg <= {1'b0, divisor_mag};
            count <= CNT_W'(WIDTH);
            q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed && dividend[WIDTH-1];
            // A zero divisor skips the iterations, so its results land now.
            if (divisor_zero) begin
                quotient    <= {WIDTH{DIV0_Q_FILL}};
                remainder   <= dividend;
                div_by_zero <= DIV0_FLAG;
            end
        end else if (state == ITER) begin
            a_reg <= a_step;
            q_reg <= q_step;
            count <= count - CNT_W'(1);
        end else if (state == FIX) begin
            quotient    <= quot_final;
            remainder   <= rem_final;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_div_nr.sv
// Directed self-checking bench for alu_div_nr at WIDTH=32.
module tb_alu_div_nr;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    alu_div_nr #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issues one request and returns the number of falling edges from the
    // accepting edge until done is seen (0 if it never appears).
    task automatic run_div(input logic s, input logic [31:0] dd, input logic [31:0] dv,
                           output int lat);
        @(negedge clk);
        start = 1'b1; is_signed = s; dividend = dd; divisor = dv;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [31:0] eq, input logic [31:0] er, input logic ez);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".quotient"}, 64'(quotient), 64'(eq));
        check({tag, ".remainder"}, 64'(remainder), 64'(er));
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(ez));
    endtask

    initial begin
        int lat;
        int d1;
        int d2;
        int done_seen;

        resetn = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.quotient", 64'(quotient), 64'd0);
        check("reset.remainder", 64'(remainder), 64'd0);
        check("reset.div_by_zero", 64'(div_by_zero), 64'd0);
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, lat);
        check_result("u100_7", lat, 34, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        check("u100_7.done_one_cycle", 64'(done), 64'd0);

        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
        check_result("s-7_2", lat, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        check_result("s7_-2", lat, 34, 32'hFFFF_FFFD, 32'd1, 1'b0);

        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat);
        check_result("s-100_-7", lat, 34, 32'd14, 32'hFFFF_FFFE, 1'b0);

        run_div(1'b0, 32'h0000_1234, 32'd0, lat);
        check_result("div0", lat, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);

        run_div(1'b1, 32'hFFFF_FF00, 32'd0, lat);
        check_result("div0_neg", lat, 1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1);

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check_result("s_ovf", lat, 34, 32'h8000_0000, 32'd0, 1'b0);

        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, lat);
        check_result("u_msb_div", lat, 34, 32'd1, 32'h7FFF_FFFF, 1'b0);

        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check_result("u_big_div", lat, 34, 32'd0, 32'h8000_0000, 1'b0);

        // Reset during the tenth iteration
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.quotient", 64'(quotient), 64'd0);
        check("abort.remainder", 64'(remainder), 64'd0);
        check("abort.div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        run_div(1'b0, 32'd1000, 32'd3, lat);
        check_result("after_abort", lat, 34, 32'd333, 32'd1, 1'b0);

        // start held high; operands and mode change while busy
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'hFFFF_FFF0; divisor = 32'd7;
        @(posedge clk);
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 5) begin
                is_signed = 1'b1; dividend = 32'hFFFF_FFCE; divisor = 32'd5;
            end
            if (done) begin
                if (d1 == 0) begin
                    d1 = i;
                    check("held.first.quotient", 64'(quotient), 64'h2492_4922);
                    check("held.first.remainder", 64'(remainder), 64'd2);
                end else begin
                    d2 = i;
                    check("held.second.quotient", 64'(quotient), 64'hFFFF_FFF6);
                    check("held.second.remainder", 64'(remainder), 64'd0);
                    break;
                end
            end
        end
        start = 1'b0;
        check("held.first.latency", 64'(d1), 64'd34);
        check("held.second.latency", 64'(d2), 64'd69);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_div_nr.md
ALU_DIV_NR -- requirements
Module: alu_div_nr

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 dividend  input  WIDTH  numerator; sampled with start.
REQ-007 divisor  input  WIDTH  denominator; sampled with start.
REQ-008 busy  output  1  high from the cycle after acceptance until done.
REQ-009 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 quotient  output  WIDTH  result quotient; held until next acceptance.
REQ-011 remainder  output  WIDTH  result remainder; held until next acceptance.
REQ-012 div_by_zero  output  1  set with done when divisor was 0; held with results.

Function
REQ-013 States IDLE, ITER, FIX, FIN; IDLE->ITER on accepted start with divisor!=0; IDLE->FIN on accepted start with divisor==0.
REQ-014 On acceptance, latch |dividend| into Q, |divisor| into M, clear A (WIDTH+1 bits), count=WIDTH, record sign of quotient (sign xor) and sign of dividend; magnitudes used only when is_signed=1.
REQ-015 ITER: one non-restoring step per cycle: shift {A,Q} left 1; A>=0 -> A-=M else A+=M; Q[0]=~A[sign]; count decrements; ITER->FIX when count reaches 0 after the step.
REQ-016 FIX: if A negative, A+=M; apply signs: quotient negated if quotient sign set, remainder negated if dividend sign set (truncating division, remainder takes dividend sign); FIX->FIN.
REQ-017 FIN: done=1 for exactly this cycle, results registered; FIN->IDLE next cycle.
REQ-018 Latency: done asserted WIDTH+2 cycles after the accepting edge for divisor!=0; 1 cycle for divisor==0.
REQ-019 Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-020 Signed overflow (most-negative / -1): quotient = most-negative value (wrap), remainder = 0, div_by_zero=0.
REQ-021 start while busy=1 or during FIN cycle ignored; start in the IDLE cycle following FIN accepted normally.
REQ-022 Unsigned mode: full WIDTH-bit unsigned range, no sign handling; is_signed change mid-operation has no effect.
REQ-023 Internal A register WIDTH+1 bits so unsigned divisors with MSB set divide correctly.

Reset
REQ-024 resetn=0 at a clock edge forces IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
REQ-025 Reset mid-operation aborts the division; no done pulse is produced for it.
REQ-026 No initial-block state dependence; all registers defined only by reset.

Structure
REQ-027 Shared package alu_div_pkg holds state enum and result-on-zero constants.
REQ-028 One sub-module alu_div_step: combinational single non-restoring iteration (A,Q,M in; A,Q out), WIDTH-parametrised.
REQ-029 No combinational path from inputs to outputs; all outputs registered.

Verification
REQ-030 WIDTH=32 unsigned 100/7 -> done at cycle 34 after acceptance, quotient 14, remainder 2, div_by_zero 0.
REQ-031 Signed -7/2 -> quotient -3 (0xFFFFFFFD), remainder -1; signed 7/-2 -> -3, remainder 1.
REQ-032 Divisor 0, dividend 0x1234 -> done next cycle, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero 1.
REQ-033 Signed 0x80000000/-1 -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/0x80000000 -> 1, remainder 0x7FFFFFFF.
REQ-034 resetn low at iteration 10 -> busy 0 next cycle, outputs 0, no done; new start after release completes correctly.
REQ-035 start held high continuously -> second operation accepted in IDLE cycle after done, starts ignored while busy.
